iobus_timer_intr: RTL

Memory-mapped timer/counter peripheral that sits on the far (responder) side of the MCU's IOBUS. It decodes IOBUS_ADDR and accepts writes from IOBUS_OUT/IOBUS_WR. It returns registered read data for the top-level IOBUS_IN mux. It drives the MCU's INTR input with a level interrupt request, held until software clears it.

---
 rtl/iobus_timer_intr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/iobus_timer_intr.sv
// Memory-mapped timer/counter on the MCU IOBUS: CTRL/PERIOD/COUNT/STATUS window,
// prescaled tick, registered read-back and a level interrupt held until W1C.
module iobus_timer_intr #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] rd_data,
    output logic        rd_sel,
    output logic        intr
);
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PERIOD = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic                  hit;
    logic [1:0]            offset;
    logic                  wr_ctrl, wr_period, wr_count, wr_status;
    logic                  en, ie, auto_reload;
    logic [PRESCALE_W-1:0] presc, pcnt;
    logic [31:0]           period, count;
    logic                  pend, ovf;
    logic                  tick, match, w1c_pend, w1c_ovf;
    logic [31:0]           ctrl_word, rd_mux;

    assign hit       = (iobus_addr[31:4] == BASE_ADDR[31:4]);
    assign offset    = iobus_addr[3:2];
    assign wr_ctrl   = iobus_wr && hit && (offset == OFF_CTRL);
    assign wr_period = iobus_wr && hit && (offset == OFF_PERIOD);
    assign wr_count  = iobus_wr && hit && (offset == OFF_COUNT);
    assign wr_status = iobus_wr && hit && (offset == OFF_STATUS);

    assign tick     = en && (pcnt == presc);
    assign match    = tick && (count == period);
    assign w1c_pend = wr_status && iobus_out[0];
    assign w1c_ovf  = wr_status && iobus_out[1];

    // A CTRL write of EN takes precedence over the one-shot auto-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en          <= 1'b0;
            ie          <= 1'b0;
            auto_reload <= 1'b0;
            presc       <= '0;
        end else if (wr_ctrl) begin
            en          <= iobus_out[0];
            ie          <= iobus_out[1];
            auto_reload <= iobus_out[2];
            presc       <= iobus_out[8 +: PRESCALE_W];
        end else if (match && !auto_reload) begin
            en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (wr_ctrl || tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
        end else if (wr_period) begin
            period <= iobus_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= iobus_out;
        end else if (tick) begin
            count <= match ? 32'd0 : count + 32'd1;
        end
    end

    // A match setting PEND wins over a same-cycle W1C, and then does not flag OVF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (match) begin
                pend <= 1'b1;
            end else if (w1c_pend) begin
                pend <= 1'b0;
            end
            if (match && pend && !w1c_pend) begin
                ovf <= 1'b1;
            end else if (w1c_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        ctrl_word                   = '0;
        ctrl_word[0]                = en;
        ctrl_word[1]                = ie;
        ctrl_word[2]                = auto_reload;
        ctrl_word[8 +: PRESCALE_W]  = presc;
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_CTRL:   rd_mux = ctrl_word;
            OFF_PERIOD: rd_mux = period;
            OFF_COUNT:  rd_mux = count;
            OFF_STATUS: rd_mux = {30'd0, ovf, pend};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_sel  <= 1'b0;
        end else begin
            rd_data <= hit ? rd_mux : 32'd0;
            rd_sel  <= hit;
        end
    end

    assign intr = pend && ie;

endmodule
